mod_exp_unit: RTL and testbench

Parametrised multi-cycle modular exponentiation engine computing `result = base^exponent mod modulus` for N-bit operands. It extends the N-bit ASIP datapath with the RSA decryption primitive (`m = c^d mod n`), which the processor pipeline launches and polls through a start/busy/done handshake. It uses right-to-left square-and-multiply built on two instances of an iterative shift-add modular multiplier.

---
 rtl/modexp_pkg.sv | 20 ++
 rtl/mod_mul.sv | 63 ++++++
 rtl/mod_exp_unit.sv | 180 ++++++++++++++++++
 tb/tb_mod_exp_unit.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/modexp_pkg.sv
// Shared types and sizing helpers for the modular exponentiation engine.
// Consumers: mod_exp_unit (top) and mod_mul (interleaved modular multiplier).
package modexp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REDUCE = 3'd1,
    ST_CHECK  = 3'd2,
    ST_MUL    = 3'd3,
    ST_DONE   = 3'd4
  } modexp_state_t;

  // Multiplier accumulator holds 2P + b < 3m, so two guard bits above N suffice.
  localparam int MUL_ACC_GUARD = 2;

  function automatic int mul_acc_width(input int n);
    return n + MUL_ACC_GUARD;
  endfunction

endpackage

// File: rtl/mod_mul.sv
// Interleaved shift-add modular multiplier: product = a * b mod m, MSB-first,
// one bit per clock, N iterations after start; done pulses after the last one.
module mod_mul #(
  parameter int N = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] m,
  output logic         done,
  output logic [N-1:0] product
);
  import modexp_pkg::*;

  localparam int AW = mul_acc_width(N);
  localparam int CW = $clog2(N + 1);

  logic [N-1:0]  a_q;
  logic [N-1:0]  b_q;
  logic [N-1:0]  m_q;
  logic [N-1:0]  p_q;
  logic [N-1:0]  p_next;
  logic [AW-1:0] t_add;
  logic [AW-1:0] t_sub;
  logic [CW-1:0] cnt;

  always_comb begin
    t_add  = (AW'(p_q) << 1) + (a_q[N-1] ? AW'(b_q) : '0);
    t_sub  = (t_add >= AW'(m_q)) ? t_add - AW'(m_q) : t_add;
    p_next = N'((t_sub >= AW'(m_q)) ? t_sub - AW'(m_q) : t_sub);
  end

  // A start while iterating simply restarts; the caller never relies on the old run.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_q  <= '0;
      b_q  <= '0;
      m_q  <= '0;
      p_q  <= '0;
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        a_q <= a;
        b_q <= b;
        m_q <= m;
        p_q <= '0;
        cnt <= CW'(N);
      end else if (cnt != '0) begin
        p_q <= p_next;
        a_q <= a_q << 1;
        cnt <= cnt - 1'b1;
        if (cnt == CW'(1)) done <= 1'b1;
      end
    end
  end

  assign product = p_q;

endmodule

// File: rtl/mod_exp_unit.sv
// Right-to-left square-and-multiply modular exponentiation, result = base^exponent mod modulus.
// Build option MODEXP_EARLY_EXIT_EN: stop when the exponent is exhausted (default: always N rounds).
//
// state  | meaning
// IDLE   | waiting for start; latches operands, launches base reduction
// REDUCE | multiplier A reduces base mod m
// CHECK  | decide whether another square/multiply round is needed
// MUL    | A squares b, B multiplies acc by b
// DONE   | one-cycle done pulse, result/error already registered
module mod_exp_unit #(
  parameter int N = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] base,
  input  logic [N-1:0] exponent,
  input  logic [N-1:0] modulus,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         error
);
  import modexp_pkg::*;

  modexp_state_t state, state_nxt;

  logic [N-1:0] m_r;
  logic [N-1:0] e_r;
  logic [N-1:0] acc_r;
  logic [N-1:0] acc_init;
  logic [N-1:0] acc_next;
  logic [N-1:0] result_r;
  logic         error_r;
  logic         loop_end;

  logic         a_start, b_start;
  logic [N-1:0] a_op_a, a_op_b, a_op_m;
  logic [N-1:0] b_op_a, b_op_b;
  logic         a_done, b_done;
  logic [N-1:0] a_prod, b_prod;

`ifdef MODEXP_EARLY_EXIT_EN
  assign loop_end = (e_r == '0);
`else
  localparam int RW = $clog2(N + 1);
  logic [RW-1:0] rnd;
  assign loop_end = (rnd == '0);
`endif

  assign acc_init = (m_r == N'(1)) ? '0 : N'(1);

  // The square b lives in A's product register. Each round's multiplies are
  // launched on the edge that enters CHECK, so a round costs N+1 edges; if
  // CHECK then ends the loop, that last launch is simply abandoned.
  always_comb begin
    state_nxt = state;
    a_start   = 1'b0;
    b_start   = 1'b0;
    acc_next  = (state == ST_REDUCE) ? acc_init : (e_r[0] ? b_prod : acc_r);
    a_op_a    = a_prod;
    a_op_b    = a_prod;
    a_op_m    = m_r;
    b_op_a    = acc_next;
    b_op_b    = a_prod;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (modulus == '0) begin
            state_nxt = ST_DONE;
          end else begin
            a_start   = 1'b1;
            a_op_a    = base;
            a_op_b    = N'(1);
            a_op_m    = modulus;
            state_nxt = ST_REDUCE;
          end
        end
      end
      ST_REDUCE: begin
        if (a_done) begin
          a_start   = 1'b1;
          b_start   = 1'b1;
          state_nxt = ST_CHECK;
        end
      end
      ST_CHECK: state_nxt = loop_end ? ST_DONE : ST_MUL;
      ST_MUL: begin
        if (a_done && b_done) begin
          a_start   = 1'b1;
          b_start   = 1'b1;
          state_nxt = ST_CHECK;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      m_r      <= '0;
      e_r      <= '0;
      acc_r    <= '0;
      result_r <= '0;
      error_r  <= 1'b0;
`ifndef MODEXP_EARLY_EXIT_EN
      rnd      <= '0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (start) begin
            m_r <= modulus;
            e_r <= exponent;
            if (modulus == '0) begin
              result_r <= '0;
              error_r  <= 1'b1;
            end
          end
        end
        ST_REDUCE: begin
          if (a_done) begin
            acc_r <= acc_next;
`ifndef MODEXP_EARLY_EXIT_EN
            rnd   <= RW'(N);
`endif
          end
        end
        // Result is registered on entry to DONE so it is valid alongside the pulse.
        ST_CHECK: begin
          if (loop_end) begin
            result_r <= acc_r;
            error_r  <= 1'b0;
          end
        end
        ST_MUL: begin
          if (a_done && b_done) begin
            acc_r <= acc_next;
            e_r   <= e_r >> 1;
`ifndef MODEXP_EARLY_EXIT_EN
            rnd   <= rnd - 1'b1;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  mod_mul #(.N(N)) u_mul_a (
    .clock   (clock),
    .reset   (reset),
    .start   (a_start),
    .a       (a_op_a),
    .b       (a_op_b),
    .m       (a_op_m),
    .done    (a_done),
    .product (a_prod)
  );

  mod_mul #(.N(N)) u_mul_b (
    .clock   (clock),
    .reset   (reset),
    .start   (b_start),
    .a       (b_op_a),
    .b       (b_op_b),
    .m       (m_r),
    .done    (b_done),
    .product (b_prod)
  );

  assign busy   = (state != ST_IDLE);
  assign done   = (state == ST_DONE);
  assign result = result_r;
  assign error  = error_r;

endmodule

// File: tb/tb_mod_exp_unit.sv
// Self-checking bench for mod_exp_unit: directed vector table, corner sequences
// (restart while busy, mid-run reset) and random operands against an arithmetic model.
module tb_mod_exp_unit;
  localparam int N = 32;
`ifdef MODEXP_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] base = '0;
  logic [N-1:0] exponent = '0;
  logic [N-1:0] modulus = '0;
  logic         busy;
  logic         done;
  logic [N-1:0] result;
  logic         error;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t0       = 0;

  mod_exp_unit #(.N(N)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .base     (base),
    .exponent (exponent),
    .modulus  (modulus),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .error    (error)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [N-1:0] b;
    logic [N-1:0] e;
    logic [N-1:0] m;
    logic [N-1:0] res;
    logic         err;
  } vec_t;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // Plain arithmetic: 64-bit products of two values below m never overflow.
  function automatic logic [N-1:0] ref_modexp(input logic [N-1:0] b, input logic [N-1:0] e,
                                              input logic [N-1:0] m);
    logic [63:0] r, x, mm;
    if (m == '0) return '0;
    mm = 64'(m);
    r  = 64'd1 % mm;
    x  = 64'(b) % mm;
    for (int i = 0; i < N; i++) begin
      if (e[i]) r = (r * x) % mm;
      x = (x * x) % mm;
    end
    return r[N-1:0];
  endfunction

  function automatic int ref_latency(input logic [N-1:0] e, input logic [N-1:0] m);
    int k;
    if (m == '0) return 0;
    k = N;
    if (EARLY) begin
      k = 0;
      for (int i = 0; i < N; i++) if (e[i]) k = i + 1;
    end
    return (N + 1) * (k + 1) + 1;
  endfunction

  task automatic launch(input logic [N-1:0] b, input logic [N-1:0] e, input logic [N-1:0] m);
    @(posedge clock); #1;
    base = b; exponent = e; modulus = m; start = 1'b1;
    @(posedge clock); #1;
    t0 = cyc;
    start = 1'b0;
    base = ~b; exponent = ~e; modulus = m + 32'd3;
  endtask

  task automatic wait_done(output int lat);
    while (done !== 1'b1 && (cyc - t0) < 4000) begin
      @(posedge clock); #1;
    end
    lat = cyc - t0;
    check("done_seen", done, 1);
  endtask

  task automatic run_check(input string name, input logic [N-1:0] b, input logic [N-1:0] e,
                           input logic [N-1:0] m, input logic [N-1:0] want_res, input logic want_err);
    int lat;
    launch(b, e, m);
    check({name, "_busy"}, busy, 1);
    wait_done(lat);
    check({name, "_latency"}, lat, ref_latency(e, m));
    check({name, "_result"}, result, want_res);
    check({name, "_error"}, error, want_err);
    @(posedge clock); #1;
    check({name, "_done_pulse"}, done, 0);
    check({name, "_busy_drop"}, busy, 0);
    check({name, "_result_hold"}, result, want_res);
  endtask

  initial begin
    vec_t vecs[7];
    int   lat;
    logic [N-1:0] rb, re, rm;

    vecs[0] = '{b: 4,    e: 13,   m: 497,  res: 445,  err: 0};
    vecs[1] = '{b: 2790, e: 2753, m: 3233, res: 65,   err: 0};
    vecs[2] = '{b: 5000, e: 1,    m: 3233, res: 1767, err: 0};
    vecs[3] = '{b: 5,    e: 0,    m: 1,    res: 0,    err: 0};
    vecs[4] = '{b: 5,    e: 0,    m: 7,    res: 1,    err: 0};
    vecs[5] = '{b: 7,    e: 5,    m: 0,    res: 0,    err: 1};
    vecs[6] = '{b: 4,    e: 13,   m: 497,  res: 445,  err: 0};

    repeat (3) @(posedge clock);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_result", result, 0);
    check("reset_error", error, 0);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_check($sformatf("vec%0d", i), vecs[i].b, vecs[i].e, vecs[i].m, vecs[i].res, vecs[i].err);
    end

    // Absolute latencies for the reference operand set.
    launch(4, 13, 497);
    repeat (10) begin
      @(posedge clock); #1;
    end
    base = 9; exponent = 3; modulus = 11; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    wait_done(lat);
    check("restart_ignored_latency", lat, EARLY ? 166 : 1090);
    check("restart_ignored_result", result, 445);
    check("restart_ignored_error", error, 0);

    launch(2790, 2753, 3233);
    wait_done(lat);
    check("rsa_latency", lat, EARLY ? 430 : 1090);
    check("rsa_result", result, 65);

    // Mid-run reset: outputs clear asynchronously, then a fresh run works.
    launch(2790, 2753, 3233);
    repeat (50) begin
      @(posedge clock); #1;
    end
    reset = 1'b1;
    #1;
    check("midreset_busy", busy, 0);
    check("midreset_done", done, 0);
    check("midreset_result", result, 0);
    check("midreset_error", error, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    run_check("after_reset", 4, 13, 497, 445, 0);

    for (int i = 0; i < 15; i++) begin
      case ($urandom_range(0, 3))
        0:       rm = N'($urandom_range(0, 20));
        1:       rm = $urandom | 32'h8000_0000;
        default: rm = $urandom;
      endcase
      rb = $urandom;
      re = ($urandom_range(0, 1) == 0) ? N'($urandom_range(0, 300)) : N'($urandom);
      run_check($sformatf("rand%0d", i), rb, re, rm, ref_modexp(rb, re, rm), rm == '0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
